// File: rtl/conv2d_kxk_stream.sv
// Streaming KxK 2-D convolution: FILTERS outputs per valid window position, signed taps and a wide accumulator.
// Define CONV_SAT_EN to saturate the narrowed result; otherwise the result wraps.
module conv2d_kxk_stream #(
    parameter int IMG_HEIGHT = 8,
    parameter int IMG_WIDTH  = 8,
    parameter int K          = 3,
    parameter int STRIDE     = 1,
    parameter int CHANNELS   = 2,
    parameter int FILTERS    = 4,
    parameter int WORD_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*WORD_WIDTH+$clog2(K*K*CHANNELS),
    parameter int OUT_SHIFT  = 0
) (
    input  logic                           i_aclk,
    input  logic                           i_aresetn,
    input  logic                           i_img_tvalid,
    output logic                           o_img_tready,
    input  logic [CHANNELS*WORD_WIDTH-1:0] i_img_tdata,
    input  logic                           i_kernel_tvalid,
    output logic                           o_kernel_tready,
    input  logic [CHANNELS*WORD_WIDTH-1:0] i_kernel_tdata,
    input  logic                           i_kernel_reload,
    output logic                           o_kernel_loaded,
    output logic                           o_out_tvalid,
    input  logic                           i_out_tready,
    output logic [WORD_WIDTH-1:0]          o_out_tdata,
    output logic                           o_out_tlast,
    output logic [1:0]                     dbg_state
);
    localparam int TAPS     = FILTERS*K*K;
    localparam int NLB      = (K > 1) ? K-1 : 1;
    localparam int RW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int CW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int FW       = (FILTERS > 1) ? $clog2(FILTERS) : 1;
    localparam int TIW      = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int LAST_ROW = K-1 + ((IMG_HEIGHT-K)/STRIDE)*STRIDE;
    localparam int LAST_COL = K-1 + ((IMG_WIDTH-K)/STRIDE)*STRIDE;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 <<< (WORD_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -ACC_WIDTH'(1 <<< (WORD_WIDTH-1));

    typedef enum logic [1:0] {LOAD = 2'd0, ACCEPT = 2'd1, EMIT = 2'd2} state_t;
    state_t state, state_next;

    logic [CHANNELS*WORD_WIDTH-1:0] taps     [TAPS];
    logic [CHANNELS*WORD_WIDTH-1:0] line_buf [NLB][IMG_WIDTH];
    logic [CHANNELS*WORD_WIDTH-1:0] win      [K][K];
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic [FW-1:0]  filt;
    logic [TIW-1:0] tap_idx;
    logic           reload_pend, last_win, honour, win_done;
    logic           img_hs, kern_hs, out_hs;
    logic signed [ACC_WIDTH-1:0]    acc, shifted;
    logic signed [2*WORD_WIDTH-1:0] prod;
    logic [WORD_WIDTH-1:0]          result;

    // Every stream uses valid/ready: a beat transfers on a rising edge where both are high;
    // a source holds its data stable while valid is high and ready is low.
    assign img_hs   = i_img_tvalid && o_img_tready;
    assign kern_hs  = i_kernel_tvalid && o_kernel_tready;
    assign out_hs   = o_out_tvalid && i_out_tready;
    assign honour   = (state == ACCEPT) && reload_pend && (row == '0) && (col == '0);
    assign win_done = (int'(row) >= K-1) && (int'(col) >= K-1) &&
                      (((int'(row) - (K-1)) % STRIDE) == 0) && (((int'(col) - (K-1)) % STRIDE) == 0);
    assign dbg_state = state;

    always_comb begin
        state_next      = state;
        o_img_tready    = 1'b0;
        o_kernel_tready = 1'b0;
        case (state)
            LOAD: begin
                o_kernel_tready = 1'b1;
                if (i_kernel_tvalid && tap_idx == TIW'(TAPS-1)) state_next = ACCEPT;
            end
            ACCEPT: begin
                o_img_tready = !honour;
                if (honour) state_next = LOAD;
                else if (i_img_tvalid && win_done) state_next = EMIT;
            end
            EMIT: begin
                if (i_out_tready && filt == FW'(FILTERS-1)) state_next = ACCEPT;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state           <= LOAD;
            row             <= '0;
            col             <= '0;
            filt            <= '0;
            tap_idx         <= '0;
            reload_pend     <= 1'b0;
            last_win        <= 1'b0;
            o_kernel_loaded <= 1'b0;
            for (int t = 0; t < TAPS; t++) taps[t] <= '0;
        end else begin
            state <= state_next;
            if (kern_hs) begin
                taps[tap_idx] <= i_kernel_tdata;
                tap_idx       <= (tap_idx == TIW'(TAPS-1)) ? '0 : tap_idx + 1'b1;
                if (tap_idx == TIW'(TAPS-1)) o_kernel_loaded <= 1'b1;
            end
            // The reload request is latched so a short pulse mid-image is honoured at the next boundary.
            if (honour) begin
                reload_pend     <= 1'b0;
                o_kernel_loaded <= 1'b0;
                tap_idx         <= '0;
            end else if (state != LOAD && i_kernel_reload) begin
                reload_pend <= 1'b1;
            end
            if (img_hs) begin
                col <= (col == CW'(IMG_WIDTH-1)) ? '0 : col + 1'b1;
                if (col == CW'(IMG_WIDTH-1)) row <= (row == RW'(IMG_HEIGHT-1)) ? '0 : row + 1'b1;
                if (win_done) last_win <= (row == RW'(LAST_ROW)) && (col == CW'(LAST_COL));
            end
            if (out_hs) filt <= (filt == FW'(FILTERS-1)) ? '0 : filt + 1'b1;
        end
    end

    // Pixel storage needs no reset: window validity comes from the counters alone.
    always_ff @(posedge i_aclk) begin
        if (img_hs) begin
            for (int j = 0; j < K-1; j++) begin
                if (j < K-2) line_buf[j][col] <= line_buf[j+1][col];
                else         line_buf[j][col] <= i_img_tdata;
            end
            for (int i = 0; i < K; i++)
                for (int kc = 0; kc < K-1; kc++) win[i][kc] <= win[i][kc+1];
            for (int i = 0; i < K-1; i++) win[i][K-1] <= line_buf[i][col];
            win[K-1][K-1] <= i_img_tdata;
        end
    end

    always_comb begin
        acc  = '0;
        prod = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    prod = $signed(win[i][j][ch*WORD_WIDTH +: WORD_WIDTH]) *
                           $signed(taps[TIW'(int'(filt)*K*K + i*K + j)][ch*WORD_WIDTH +: WORD_WIDTH]);
                    acc  = acc + ACC_WIDTH'(prod);
                end
        shifted = acc >>> OUT_SHIFT;
`ifdef CONV_SAT_EN
        if (shifted > SAT_MAX)      result = SAT_MAX[WORD_WIDTH-1:0];
        else if (shifted < SAT_MIN) result = SAT_MIN[WORD_WIDTH-1:0];
        else                        result = shifted[WORD_WIDTH-1:0];
`else
        result = shifted[WORD_WIDTH-1:0];
`endif
    end

    assign o_out_tvalid = (state == EMIT);
    assign o_out_tdata  = o_out_tvalid ? result : '0;
    assign o_out_tlast  = o_out_tvalid && last_win && (filt == FW'(FILTERS-1));
endmodule
